// File: rtl/mult_share_arbiter_if.sv
// ============================================================================
// Module   : mult_share_arbiter_if
// Brief    : Request, shared-multiplier and response signals of the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [2*WIDTH-1:0]       mul_result;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_result;
  logic                     busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, mul_result, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
  );

  // Requesters, response consumer and multiplier side
  modport master (
    output req_valid, req_a, req_b, mul_result, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result, busy
  );
endinterface

`default_nettype wire

// File: rtl/mult_share_arbiter.sv
// ============================================================================
// Module   : mult_share_arbiter
// Brief    : Round-robin sequencer sharing one multiplier among NUM_REQ users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.slave  bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_MUL  = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   c_NUM_REQ   = (ID_W + 1)'(NUM_REQ);

  logic [1:0]         r_state;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last_grant;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [2*WIDTH-1:0] r_rsp_result;

  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_grant;
  logic               w_found;
  logic [NUM_REQ-1:0] w_req_ready;
  logic               w_hs;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;

  // Search starts just past the last winner; one extra bit holds the wrap.
  always_comb begin
    w_sum   = '0;
    w_grant = '0;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_last_grant} + (ID_W + 1)'(k + 1);
      if (w_sum >= c_NUM_REQ) begin
        w_sum = w_sum - c_NUM_REQ;
      end
      if (!w_found && bus.req_valid[w_sum[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant == ID_W'(k)) begin
        w_sel_a = bus.req_a[k*WIDTH +: WIDTH];
        w_sel_b = bus.req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_req_ready = (rst_n && (r_state == c_IDLE) && w_found)
                     ? (NUM_REQ'(1) << w_grant) : '0;
  assign w_hs        = |(w_req_ready & bus.req_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_id         <= '0;
      r_last_grant <= c_LAST_INIT;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_hs) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_id         <= w_grant;
            r_last_grant <= w_grant;
            r_state      <= c_MUL;
          end
        end
        c_MUL: begin
          r_rsp_result <= bus.mul_result;
          r_rsp_id     <= r_id;
          r_rsp_valid  <= 1'b1;
          r_state      <= c_RESP;
        end
        c_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.mul_a      = r_op_a;
  assign bus.mul_b      = r_op_b;
  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.rsp_id     = r_rsp_id;
  assign bus.rsp_result = r_rsp_result;
  assign bus.busy       = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mult_share_arbiter.sv
// ============================================================================
// Module   : tb_mult_share_arbiter
// Brief    : Directed self-checking bench for mult_share_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_share_arbiter;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  mult_share_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  mult_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Shared combinational multiplier
  assign bus.mul_result = {{WIDTH{1'b0}}, bus.mul_a} * {{WIDTH{1'b0}}, bus.mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, requests presented while reset is held
    cyc();
    cyc();
    bus.req_valid = 4'hF;
    #1;
    check("rst_ready",  32'(bus.req_ready),  32'h0);
    check("rst_valid",  32'(bus.rsp_valid),  32'h0);
    check("rst_busy",   32'(bus.busy),       32'h0);
    check("rst_mul_a",  32'(bus.mul_a),      32'h0);
    check("rst_mul_b",  32'(bus.mul_b),      32'h0);
    check("rst_id",     32'(bus.rsp_id),     32'h0);
    check("rst_result", 32'(bus.rsp_result), 32'h0);
    do_reset();

    // 1: single request 2 x 1
    set_op(0, 4'd2, 4'd1);
    bus.req_valid = 4'b0001;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = '0;
    check("t1_mul_busy",  32'(bus.busy),      32'h1);
    check("t1_mul_ready", 32'(bus.req_ready), 32'h0);
    check("t1_mul_a",     32'(bus.mul_a),     32'h2);
    check("t1_mul_b",     32'(bus.mul_b),     32'h1);
    check("t1_mul_valid", 32'(bus.rsp_valid), 32'h0);
    cyc();
    check("t1_valid",  32'(bus.rsp_valid),  32'h1);
    check("t1_id",     32'(bus.rsp_id),     32'h0);
    check("t1_result", 32'(bus.rsp_result), 32'h02);
    bus.rsp_ready = 1'b1;
    cyc();
    check("t1_done_valid", 32'(bus.rsp_valid), 32'h0);
    check("t1_done_busy",  32'(bus.busy),      32'h0);

    // 2: contention between req 0 (5x3) and req 1 (15x10)
    do_reset();
    set_op(0, 4'd5, 4'd3);
    set_op(1, 4'd15, 4'd10);
    bus.req_valid = 4'b0011;
    #1;
    check("t2_ready0", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 4'b0010;
    cyc();
    check("t2_id0",  32'(bus.rsp_id),     32'h0);
    check("t2_res0", 32'(bus.rsp_result), 32'h0F);
    cyc();
    check("t2_ready1", 32'(bus.req_ready), 32'h2);
    cyc();
    bus.req_valid = '0;
    cyc();
    check("t2_valid1", 32'(bus.rsp_valid),  32'h1);
    check("t2_id1",    32'(bus.rsp_id),     32'h1);
    check("t2_res1",   32'(bus.rsp_result), 32'h96);
    cyc();

    // 3: fairness with all requesters continuously valid
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      set_op(i, 4'(i + 1), 4'(i + 2));
    end
    bus.req_valid = 4'hF;
    #1;
    for (int s = 0; s < 8; s++) begin
      check("t3_grant", 32'(bus.req_ready), 32'(1 << (s % 4)));
      cyc();
      check("t3_mul_ready", 32'(bus.req_ready), 32'h0);
      cyc();
      check("t3_id",     32'(bus.rsp_id),     32'(s % 4));
      check("t3_result", 32'(bus.rsp_result), 32'(((s % 4) + 1) * ((s % 4) + 2)));
      cyc();
    end
    bus.req_valid = '0;

    // 4: backpressure on a 15x15 response
    bus.rsp_ready = 1'b0;
    set_op(2, 4'd15, 4'd15);
    bus.req_valid = 4'b0100;
    #1;
    check("t4_ready", 32'(bus.req_ready), 32'h4);
    cyc();
    bus.req_valid = 4'hF;
    cyc();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid",  32'(bus.rsp_valid),  32'h1);
      check("t4_hold_result", 32'(bus.rsp_result), 32'hE1);
      check("t4_hold_ready",  32'(bus.req_ready),  32'h0);
      check("t4_hold_busy",   32'(bus.busy),       32'h1);
      cyc();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    #1;
    check("t4_pre_busy", 32'(bus.busy), 32'h1);
    cyc();
    check("t4_idle_busy",  32'(bus.busy),      32'h0);
    check("t4_idle_valid", 32'(bus.rsp_valid), 32'h0);

    // 5: zero operands from req 3, then req 3 again after pointer wrap
    set_op(3, 4'd0, 4'd0);
    bus.req_valid = 4'b1000;
    #1;
    check("t5_ready_a", 32'(bus.req_ready), 32'h8);
    cyc();
    set_op(3, 4'd3, 4'd5);
    cyc();
    check("t5_id_a",     32'(bus.rsp_id),     32'h3);
    check("t5_result_a", 32'(bus.rsp_result), 32'h00);
    cyc();
    check("t5_ready_b", 32'(bus.req_ready), 32'h8);
    cyc();
    bus.req_valid = '0;
    cyc();
    check("t5_id_b",     32'(bus.rsp_id),     32'h3);
    check("t5_result_b", 32'(bus.rsp_result), 32'h0F);
    cyc();
    check("t5_keep_a", 32'(bus.mul_a), 32'h3);
    check("t5_keep_b", 32'(bus.mul_b), 32'h5);

    // 6: reset while in MUL discards the in-flight result
    set_op(1, 4'd7, 4'd7);
    bus.req_valid = 4'b0010;
    cyc();
    bus.req_valid = '0;
    check("t6_in_mul", 32'(bus.busy), 32'h1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    check("t6_valid", 32'(bus.rsp_valid), 32'h0);
    check("t6_busy",  32'(bus.busy),      32'h0);
    check("t6_mul_a", 32'(bus.mul_a),     32'h0);
    check("t6_mul_b", 32'(bus.mul_b),     32'h0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("t6_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    set_op(0, 4'd6, 4'd2);
    set_op(2, 4'd9, 4'd9);
    bus.req_valid = 4'b0101;
    #1;
    check("t6_ready0", 32'(bus.req_ready), 32'h1);
    cyc();
    bus.req_valid = 4'b0100;
    cyc();
    check("t6_id0",  32'(bus.rsp_id),     32'h0);
    check("t6_res0", 32'(bus.rsp_result), 32'h0C);
    cyc();
    check("t6_ready2", 32'(bus.req_ready), 32'h4);
    bus.req_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Sequencer and round-robin arbiter that shares one combinational array multiplier (WIDTH x WIDTH -> 2*WIDTH) among NUM_REQ requesters.
- Accepts one operand pair at a time over a valid/ready handshake and drives it to the multiplier instance.
- Registers the product and returns it with the requester ID over a valid/ready response channel.
- Sits between requesting datapath blocks and the single shared array_multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- WIDTH, 4, operand width; must match the multiplier instance.
- ID_W, derived as clog2(NUM_REQ), width of rsp_id; not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a  in  NUM_REQ*WIDTH  flattened A operands; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened B operands; same packing as req_a.
- mul_a  out  WIDTH  A operand driven to the shared multiplier.
- mul_b  out  WIDTH  B operand driven to the shared multiplier.
- mul_result  in  2*WIDTH  product returned by the shared multiplier.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_result  out  2*WIDTH  registered product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-low, sampled on the clk rising edge.
- Reset values:
  - state = IDLE.
  - Operand registers = 0, so mul_a = mul_b = 0.
  - rsp_valid = 0, rsp_id = 0, rsp_result = 0, busy = 0.
  - req_ready = 0 while rst_n is low.
  - Round-robin pointer last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - grant = first i with req_valid[i] = 1, searching from last_grant+1 upward with wrap-around modulo NUM_REQ.
  - req_ready[grant] = 1 combinationally. All other req_ready bits are 0, and all are 0 if no request is valid.
  - On a clock edge with a handshake: latch req_a/req_b slices into the operand registers, latch grant into the ID register, set last_grant = grant, go to MUL.
- MUL:
  - mul_a/mul_b come from the operand registers, which are stable for the whole state.
  - On the next edge: rsp_result <= mul_result, rsp_id <= ID register, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid = 1. rsp_result and rsp_id are held stable until the handshake.
  - On an edge with rsp_ready = 1: rsp_valid <= 0, go to IDLE.
- req_ready is 0 in MUL and RESP. No new request is accepted until the FSM is back in IDLE.
- Latency: handshake on edge E0 gives rsp_valid = 1 after E1. Minimum issue interval is 3 cycles (IDLE, MUL, RESP with rsp_ready = 1).
- Requester obligation: hold req_valid and the operands until req_ready. Dropping req_valid before req_ready is legal; that request is simply never served.
- Operands keep their values between operations; they are not cleared after use.
- Multiplication is unsigned. The product is full width 2*WIDTH with no truncation.
- Boundary conditions:
  - Simultaneous requests: one grant per cycle, in round-robin order. Losing requesters wait with no starvation; worst-case wait is NUM_REQ-1 services.
  - Pointer wrap: after granting requester NUM_REQ-1, the search restarts at 0.
  - Reset in any state: everything returns to the reset values on the next edge. An in-flight result is discarded, not delivered.
  - rsp_ready high while rsp_valid is low has no effect.

Test Plan:
1. Single request: req 0 with a = 4'b0010, b = 4'b0001 → req_ready[0] high in the same cycle; 2 edges later rsp_valid = 1, rsp_id = 0, rsp_result = 8'h02.
2. Contention: req 0 (5 x 3) and req 1 (15 x 10) valid together, rsp_ready = 1 → first response id 0, result 8'h0F; then id 1, result 8'h96. Each issue is 3 cycles apart.
3. Fairness: all 4 requesters continuously valid for 8 services → grant order 0,1,2,3,0,1,2,3; exactly one req_ready bit high per IDLE cycle.
4. Backpressure: rsp_ready = 0 for 5 cycles after a 15 x 15 request → rsp_valid stays 1, rsp_result = 8'hE1 stays stable, req_ready = 0 and busy = 1 throughout; IDLE is reached one edge after rsp_ready rises.
5. Zero operands and pointer state: 0 x 0 → rsp_result = 8'h00; after serving req 3, a new request from req 3 alone is still granted, with no deadlock on wrap.
6. Reset mid-operation: rst_n low for one edge while in MUL → rsp_valid = 0, busy = 0, mul_a = mul_b = 0, no response emitted. With req 2 and req 0 valid afterwards, req 0 is granted first.
